// File: rtl/serial_row_loader.sv
// Row framing after the serial-to-parallel shifter: counts data_size bit strobes,
// captures the completed word into a one-entry buffer and hands it off with a row address.
module serial_row_loader #(
    parameter int unsigned data_size = 64,
    parameter int unsigned num_rows  = 64,
    localparam int unsigned BW = (data_size > 1) ? $clog2(data_size) : 1,
    localparam int unsigned AW = (num_rows > 1) ? $clog2(num_rows) : 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [data_size-1:0] DATA,
    input  logic                 CLEAR,
    input  logic                 ROW_READY,
    output logic [data_size-1:0] ROW_DATA,
    output logic [AW-1:0]        ROW_ADDR,
    output logic                 ROW_VALID,
    output logic                 FRAME_DONE,
    output logic                 OVERFLOW
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    localparam logic [BW-1:0] LAST_BIT = BW'(data_size - 1);
    localparam logic [AW-1:0] LAST_ROW = AW'(num_rows - 1);

    state_e               state_q, state_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]        row_cnt_q, row_cnt_d;
    logic                 cap_pend_q, cap_pend_d;
    logic [data_size-1:0] row_data_q, row_data_d;
    logic [AW-1:0]        row_addr_q, row_addr_d;
    logic                 frame_done_q, frame_done_d;
    logic                 overflow_q, overflow_d;
    logic                 handshake;
    logic                 store;

    // State register; ROW_DATA lives here too so reset clears it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_EMPTY;
            bit_cnt_q    <= '0;
            row_cnt_q    <= '0;
            cap_pend_q   <= 1'b0;
            row_data_q   <= '0;
            row_addr_q   <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            row_cnt_q    <= row_cnt_d;
            cap_pend_q   <= cap_pend_d;
            row_data_q   <= row_data_d;
            row_addr_q   <= row_addr_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state: bit counting, delayed capture, buffer FSM and handoff flags.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        row_cnt_d    = row_cnt_q;
        cap_pend_d   = cap_pend_q;
        row_data_d   = row_data_q;
        row_addr_d   = row_addr_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;

        handshake = (state_q == S_FULL) && ROW_READY;
        store     = cap_pend_q && ((state_q == S_EMPTY) || handshake);

        if (CLEAR) begin
            state_d    = S_EMPTY;
            bit_cnt_d  = '0;
            row_cnt_d  = '0;
            cap_pend_d = 1'b0;
            row_addr_d = '0;
            overflow_d = 1'b0;
        end else begin
            // DATA holds the complete row only in the cycle after the last strobe.
            if (cap_pend_q) begin
                cap_pend_d = 1'b0;
                row_cnt_d  = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + AW'(1);
                if (store) begin
                    row_data_d = DATA;
                    row_addr_d = row_cnt_q;
                end else begin
                    overflow_d = 1'b1;
                end
            end

            if (EN) begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d  = '0;
                    cap_pend_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end

            if (store) begin
                state_d = S_FULL;
            end else if (handshake) begin
                state_d = S_EMPTY;
            end

            if (handshake && (row_addr_q == LAST_ROW)) begin
                frame_done_d = 1'b1;
            end
        end
    end

    assign ROW_DATA   = row_data_q;
    assign ROW_ADDR   = row_addr_q;
    assign ROW_VALID  = (state_q == S_FULL);
    assign FRAME_DONE = frame_done_q;
    assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_serial_row_loader.sv
// Bench for serial_row_loader: models the upstream shifter, checks handoffs against a
// scoreboard of expected rows, plus directed backpressure / zero-bubble / reset / clear cases.
module tb_serial_row_loader;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;
    localparam int unsigned AW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } exp_t;

    typedef struct packed {
        logic [DW-1:0] bits;
        logic [AW-1:0] exp_addr;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          EN;
    logic          CLEAR;
    logic          ROW_READY;
    logic [DW-1:0] DATA;
    logic [DW-1:0] ROW_DATA;
    logic [AW-1:0] ROW_ADDR;
    logic          ROW_VALID;
    logic          FRAME_DONE;
    logic          OVERFLOW;

    logic          ser = 1'b0;
    logic [DW-1:0] sr  = '0;

    int total = 0;
    int bad   = 0;
    int fd_pulses = 0;

    exp_t sb_q[$];
    vec_t vecs[5];

    logic          fd_exp = 1'b0;
    logic          hold   = 1'b0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic          hs;
    exp_t          e;

    serial_row_loader #(.data_size(DW), .num_rows(NR)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DATA(DATA), .CLEAR(CLEAR), .ROW_READY(ROW_READY),
        .ROW_DATA(ROW_DATA), .ROW_ADDR(ROW_ADDR), .ROW_VALID(ROW_VALID),
        .FRAME_DONE(FRAME_DONE), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Upstream shift register, MSB first, never cleared.
    always @(posedge CLK) if (EN) sr <= {sr[DW-2:0], ser};
    assign DATA = sr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        EN  = 1'b1;
        ser = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_row(input logic [DW-1:0] b);
        for (int i = DW - 1; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic idle(input int n);
        EN = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] a);
        sb_q.push_back({d, a});
    endtask

    // Handoff monitor: inputs settle after each rising edge, so the falling edge
    // sees exactly what the next rising edge will act on.
    always @(negedge CLK) begin
        if (RST) begin
            fd_exp = 1'b0;
            hold   = 1'b0;
        end else begin
            check("frame_done", FRAME_DONE, fd_exp);
            if (FRAME_DONE) fd_pulses++;
            if (hold) begin
                check("held_valid", ROW_VALID, 1'b1);
                check("held_data", ROW_DATA, prev_data);
                check("held_addr", ROW_ADDR, prev_addr);
            end
            hs     = ROW_VALID && ROW_READY && !CLEAR;
            fd_exp = 1'b0;
            if (hs) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_row", 1'b1, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", ROW_DATA, e.data);
                    check("sb_addr", ROW_ADDR, e.addr);
                    fd_exp = (e.addr == AW'(NR - 1));
                end
            end
            hold      = ROW_VALID && !hs && !CLEAR;
            prev_data = ROW_DATA;
            prev_addr = ROW_ADDR;
        end
    end

    initial begin
        vecs[0] = {8'hA5, 2'd0};
        vecs[1] = {8'h3C, 2'd1};
        vecs[2] = {8'h0F, 2'd2};
        vecs[3] = {8'hF0, 2'd3};
        vecs[4] = {8'h99, 2'd0};

        RST = 1'b1; EN = 1'b0; CLEAR = 1'b0; ROW_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_data", ROW_DATA, 0);
        check("rst_addr", ROW_ADDR, 0);
        check("rst_valid", ROW_VALID, 0);
        check("rst_frame_done", FRAME_DONE, 0);
        check("rst_overflow", OVERFLOW, 0);
        RST = 1'b0;

        // Continuous EN with ROW_READY high across a frame wrap.
        ROW_READY = 1'b1;
        fd_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].bits, vecs[i].exp_addr);
            send_bit(vecs[i].bits[DW-1]);
            if (i > 0) begin
                check("lat_valid", ROW_VALID, 1'b1);
                check("lat_data", ROW_DATA, vecs[i-1].bits);
                check("lat_addr", ROW_ADDR, vecs[i-1].exp_addr);
            end
            for (int j = DW - 2; j >= 0; j--) send_bit(vecs[i].bits[j]);
            check("pre_capture_valid", ROW_VALID, 1'b0);
        end
        idle(1);
        check("last_valid", ROW_VALID, 1'b1);
        check("last_data", ROW_DATA, vecs[4].bits);
        check("last_addr", ROW_ADDR, vecs[4].exp_addr);
        idle(2);
        check("frame_done_pulses", fd_pulses, 1);
        check("stream_overflow", OVERFLOW, 1'b0);

        // Backpressure: row 0 held, row 1 dropped, row 2 keeps its address.
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        ROW_READY = 1'b0;
        push(8'h11, 2'd0);
        send_row(8'h11);
        send_row(8'h22);
        idle(2);
        check("bp_valid", ROW_VALID, 1'b1);
        check("bp_data", ROW_DATA, 8'h11);
        check("bp_addr", ROW_ADDR, 2'd0);
        check("bp_overflow", OVERFLOW, 1'b1);
        ROW_READY = 1'b1;
        idle(1);
        check("bp_drained", ROW_VALID, 1'b0);
        push(8'h33, 2'd2);
        send_row(8'h33);
        idle(3);
        check("overflow_sticky", OVERFLOW, 1'b1);

        CLEAR = 1'b1;
        @(posedge CLK); #1;
        CLEAR = 1'b0;
        check("clr_overflow", OVERFLOW, 1'b0);
        check("clr_valid", ROW_VALID, 1'b0);
        check("clr_data_kept", ROW_DATA, 8'h33);
        check("clr_addr", ROW_ADDR, 2'd0);

        // Zero-bubble: ROW_READY high only on the capture edge while FULL.
        ROW_READY = 1'b0;
        push(8'h44, 2'd0);
        push(8'h55, 2'd1);
        send_row(8'h44);
        send_row(8'h55);
        EN = 1'b0;
        ROW_READY = 1'b1;
        @(posedge CLK); #1;
        ROW_READY = 1'b0;
        check("zb_valid", ROW_VALID, 1'b1);
        check("zb_data", ROW_DATA, 8'h55);
        check("zb_addr", ROW_ADDR, 2'd1);
        check("zb_overflow", OVERFLOW, 1'b0);
        ROW_READY = 1'b1;
        idle(2);

        // Asynchronous reset after 5 of 8 bits.
        for (int j = DW - 1; j >= 3; j--) send_bit(8'h66 >> j);
        #1;
        EN  = 1'b0;
        RST = 1'b1;
        #1;
        check("arst_data", ROW_DATA, 0);
        check("arst_addr", ROW_ADDR, 0);
        check("arst_valid", ROW_VALID, 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        push(8'h77, 2'd0);
        send_row(8'h77);
        idle(3);

        // CLEAR together with the 8th EN: no capture, counters restart.
        for (int j = DW - 1; j >= 1; j--) send_bit(8'h88 >> j);
        EN    = 1'b1;
        ser   = 1'b0;
        CLEAR = 1'b1;
        @(posedge CLK); #1;
        CLEAR = 1'b0;
        idle(3);
        check("clr_no_capture", ROW_VALID, 1'b0);
        check("clr_row_data_kept", ROW_DATA, 8'h77);
        push(8'hC3, 2'd0);
        send_row(8'hC3);
        idle(3);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
